// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - opcodes, fetch states and fault bit positions shared by the fetch unit
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } fetch_state_t;

  localparam int FAULT_OVERRUN    = 0;
  localparam int FAULT_MISALIGNED = 1;
  localparam int FAULT_TIMEOUT    = 2;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction-memory read bus between fetch unit and memory
interface instr_fetch_unit_if;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_ready
  );

endinterface

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - sign-extended immediate decode from a raw instruction word
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (instr[6:0])
      OP_LOAD, OP_IMM, OP_JALR: imm = {{20{instr[31]}}, instr[31:20]};
      OP_STORE:                 imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:                imm = {{19{instr[31]}}, instr[31], instr[7],
                                       instr[30:25], instr[11:8], 1'b0};
      OP_LUI:                   imm = {instr[31:12], 12'b0};
      default:                  imm = '0;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC register, instruction fetch FSM with timeout, IR and field decode
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_ir,
  input  logic                pc_write,
  input  logic                pc_write_cond,
  input  logic                alu_zero,
  input  logic                sel_mux_pc,
  input  logic [31:0]         alu_result,
  input  logic [31:0]         alu_out,
  instr_fetch_unit_if.master  mem,
  output logic [31:0]         pc,
  output logic [31:0]         instr,
  output logic                ir_valid,
  output logic                busy,
  output logic [6:0]          opcode,
  output logic [4:0]          rd,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [2:0]          funct3,
  output logic [6:0]          funct7,
  output logic [31:0]         imm,
  output logic [2:0]          fault
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  fetch_state_t     state, state_next;
  logic [CNT_W-1:0] counter;
  logic             latch_addr, capture, zero_instr;
  logic             set_misaligned, set_timeout, cnt_clr, cnt_inc;
  logic             pc_load, overrun_hit;

  assign pc_load     = pc_write | (pc_write_cond & alu_zero);
  assign overrun_hit = load_ir && (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next     = state;
    mem.mem_req    = 1'b0;
    busy           = 1'b0;
    ir_valid       = 1'b0;
    latch_addr     = 1'b0;
    capture        = 1'b0;
    zero_instr     = 1'b0;
    set_misaligned = 1'b0;
    set_timeout    = 1'b0;
    cnt_clr        = 1'b0;
    cnt_inc        = 1'b0;
    case (state)
      IDLE: begin
        if (load_ir) begin
          if (pc[1:0] != 2'b00) begin
            zero_instr     = 1'b1;
            set_misaligned = 1'b1;
            state_next     = DONE;
          end else begin
            latch_addr = 1'b1;
            state_next = REQ;
          end
        end
      end
      REQ: begin
        mem.mem_req = 1'b1;
        busy        = 1'b1;
        cnt_clr     = 1'b1;
        state_next  = WAIT;
      end
      WAIT: begin
        mem.mem_req = 1'b1;
        busy        = 1'b1;
        // A ready in the final allowed cycle still wins over the abort.
        if (mem.mem_ready) begin
          capture    = 1'b1;
          state_next = DONE;
        end else if (counter == CNT_W'(TIMEOUT - 1)) begin
          set_timeout = 1'b1;
          zero_instr  = 1'b1;
          state_next  = DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DONE: begin
        ir_valid   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      instr        <= '0;
      mem.mem_addr <= '0;
      counter      <= '0;
      fault        <= '0;
    end else begin
      if (pc_load)    pc <= sel_mux_pc ? alu_out : alu_result;
      // Address is frozen at fetch start so PC writes cannot redirect a fetch in flight.
      if (latch_addr) mem.mem_addr <= pc;
      if (capture)         instr <= mem.mem_rdata;
      else if (zero_instr) instr <= '0;
      if (cnt_clr)      counter <= '0;
      else if (cnt_inc) counter <= counter + CNT_W'(1);
      if (set_timeout)    fault[FAULT_TIMEOUT]    <= 1'b1;
      if (set_misaligned) fault[FAULT_MISALIGNED] <= 1'b1;
      if (overrun_hit)    fault[FAULT_OVERRUN]    <= 1'b1;
    end
  end

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  imm_gen u_imm_gen (
    .instr (instr),
    .imm   (imm)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed and randomized self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          TIMEOUT  = 15;
  localparam logic [6:0]  OPS [7]  = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011,
                                       7'b1100011, 7'b0110111, 7'b0110011};

  logic        clk = 1'b0;
  logic        rst, load_ir, pc_write, pc_write_cond, alu_zero, sel_mux_pc;
  logic [31:0] alu_result, alu_out, pc, instr, imm;
  logic        ir_valid, busy;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3, fault;

  instr_fetch_unit_if mif ();

  instr_fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .load_ir       (load_ir),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .alu_zero      (alu_zero),
    .sel_mux_pc    (sel_mux_pc),
    .alu_result    (alu_result),
    .alu_out       (alu_out),
    .mem           (mif),
    .pc            (pc),
    .instr         (instr),
    .ir_valid      (ir_valid),
    .busy          (busy),
    .opcode        (opcode),
    .rd            (rd),
    .rs1           (rs1),
    .rs2           (rs2),
    .funct3        (funct3),
    .funct7        (funct7),
    .imm           (imm),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_pc, m_instr;
  logic [2:0]  m_fault;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    int v;
    case (w[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: begin
        v = int'(w[31:20]);
        if (v >= 2048) v -= 4096;
      end
      7'b0100011: begin
        v = int'(w[31:25]) * 32 + int'(w[11:7]);
        if (v >= 2048) v -= 4096;
      end
      7'b1100011: begin
        v = int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      7'b0110111: v = int'(w & 32'hFFFF_F000);
      default:    v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom();
    return {r[31:7], OPS[$urandom_range(0, 6)]};
  endfunction

  task automatic chk_decode();
    logic [31:0] w;
    w = m_instr;
    chk("opcode", 32'(opcode), 32'(w[6:0]));
    chk("rd",     32'(rd),     32'(w[11:7]));
    chk("funct3", 32'(funct3), 32'(w[14:12]));
    chk("rs1",    32'(rs1),    32'(w[19:15]));
    chk("rs2",    32'(rs2),    32'(w[24:20]));
    chk("funct7", 32'(funct7), 32'(w[31:25]));
    chk("imm",    imm,         ref_imm(w));
  endtask

  task automatic pc_upd(input bit pw, input bit pwc, input bit zero, input bit sel,
                        input logic [31:0] res, input logic [31:0] out);
    pc_write = pw; pc_write_cond = pwc; alu_zero = zero; sel_mux_pc = sel;
    alu_result = res; alu_out = out;
    tick();
    pc_write = 1'b0; pc_write_cond = 1'b0; alu_zero = 1'b0;
    if (pw | (pwc & zero)) m_pc = sel ? out : res;
    chk("pc_upd", pc, m_pc);
  endtask

  // wait_n >= TIMEOUT means memory never answers; poke_at injects load_ir + pc_write mid-fetch
  task automatic fetch(input int wait_n, input logic [31:0] data, input bit pcw_start,
                       input logic [31:0] pcw_val, input int poke_at, input bit ready_in_req);
    logic [31:0] addr_exp, exp_instr;
    int          lat, exp_lat;
    bit          seen;
    addr_exp = m_pc;
    load_ir  = 1'b1;
    if (pcw_start) begin
      pc_write = 1'b1; sel_mux_pc = 1'b0; alu_result = pcw_val;
    end
    tick();
    load_ir  = 1'b0;
    pc_write = 1'b0;
    if (pcw_start) m_pc = pcw_val;
    lat  = 1;
    seen = 1'b0;
    chk("req_pulse", 32'(mif.mem_req), 1);
    chk("req_addr", mif.mem_addr, addr_exp);
    if (wait_n < TIMEOUT) begin
      exp_lat = 3 + wait_n; exp_instr = data;
    end else begin
      exp_lat = 2 + TIMEOUT; exp_instr = '0;
    end
    while (!seen && lat < 40) begin
      chk("busy", 32'(busy), 1);
      mif.mem_rdata = $urandom();
      mif.mem_ready = 1'b0;
      if (lat == 1 && ready_in_req) mif.mem_ready = 1'b1;
      if (wait_n < TIMEOUT && lat - 2 == wait_n) begin
        mif.mem_ready = 1'b1; mif.mem_rdata = data;
      end
      if (lat == poke_at) begin
        load_ir = 1'b1; pc_write = 1'b1; sel_mux_pc = 1'b0; alu_result = pcw_val;
      end
      tick();
      lat++;
      if (lat - 1 == poke_at) begin
        load_ir = 1'b0; pc_write = 1'b0;
        m_pc = pcw_val; m_fault[0] = 1'b1;
        chk("inflight_pc", pc, m_pc);
        chk("inflight_addr", mif.mem_addr, addr_exp);
        chk("overrun_flag", 32'(fault[0]), 1);
      end
      mif.mem_ready = 1'b0;
      seen = ir_valid;
    end
    chk("latency", lat, exp_lat);
    m_instr = exp_instr;
    if (wait_n >= TIMEOUT) m_fault[2] = 1'b1;
    chk("instr", instr, m_instr);
    chk("fault", 32'(fault), 32'(m_fault));
    chk("addr_hold", mif.mem_addr, addr_exp);
    chk_decode();
    tick();
    chk("ir_pulse_end", 32'(ir_valid), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_req", 32'(mif.mem_req), 0);
  endtask

  task automatic fetch_misaligned();
    load_ir = 1'b1;
    tick();
    load_ir = 1'b0;
    m_instr = '0;
    m_fault[1] = 1'b1;
    chk("mis_req", 32'(mif.mem_req), 0);
    chk("mis_valid", 32'(ir_valid), 1);
    chk("mis_instr", instr, m_instr);
    chk("mis_fault", 32'(fault), 32'(m_fault));
    tick();
    chk("mis_pulse_end", 32'(ir_valid), 0);
    chk("mis_busy", 32'(busy), 0);
  endtask

  initial begin
    int wn;
    rst = 1'b1; load_ir = 1'b0; pc_write = 1'b0; pc_write_cond = 1'b0; alu_zero = 1'b0;
    sel_mux_pc = 1'b0; alu_result = '0; alu_out = '0;
    mif.mem_ready = 1'b0; mif.mem_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
    m_pc = RESET_PC; m_instr = '0; m_fault = '0;

    chk("rst_pc", pc, RESET_PC);
    chk("rst_instr", instr, 0);
    chk("rst_addr", mif.mem_addr, 0);
    chk("rst_req", 32'(mif.mem_req), 0);
    chk("rst_valid", 32'(ir_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fault", 32'(fault), 0);

    fetch(0, 32'h0050_0093, 1'b0, '0, -1, 1'b0);
    chk("addi_rd", 32'(rd), 1);
    chk("addi_imm", imm, 5);

    pc_upd(1'b0, 1'b1, 1'b1, 1'b1, 32'h1234, 32'h40);
    chk("branch_taken", pc, 32'h40);
    pc_upd(1'b0, 1'b1, 1'b0, 1'b1, 32'h1234, 32'h80);
    chk("branch_not_taken", pc, 32'h40);

    fetch(TIMEOUT, 32'hDEAD_BEEF, 1'b0, '0, -1, 1'b0);
    chk("timeout_flag", 32'(fault[2]), 1);

    pc_upd(1'b1, 1'b0, 1'b0, 1'b0, 32'h6, 32'h0);
    fetch_misaligned();

    pc_upd(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h200);
    fetch(4, rand_instr(), 1'b0, 32'h100, 3, 1'b0);
    chk("overrun_pc", pc, 32'h100);

    fetch(1, rand_instr(), 1'b1, 32'h300, -1, 1'b1);
    chk("same_cycle_pc", pc, 32'h300);

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 1) == 1)
        pc_upd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC, $urandom() & 32'hFFFF_FFFC);
      wn = ($urandom_range(0, 7) == 0) ? TIMEOUT : int'($urandom_range(0, 4));
      fetch(wn, rand_instr(), 1'($urandom_range(0, 3) == 0), $urandom() & 32'hFFFF_FFFC,
            (wn > 0 && $urandom_range(0, 3) == 0) ? 2 : -1, 1'($urandom_range(0, 1)));
    end

    load_ir = 1'b1;
    tick();
    load_ir = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_pc = RESET_PC; m_instr = '0; m_fault = '0;
    for (int k = 0; k < 3; k++) begin
      mif.mem_ready = 1'b1;
      mif.mem_rdata = $urandom();
      tick();
      chk("rst_wait_valid", 32'(ir_valid), 0);
      chk("rst_wait_busy", 32'(busy), 0);
      chk("rst_wait_instr", instr, m_instr);
    end
    mif.mem_ready = 1'b0;
    chk("rst_wait_pc", pc, m_pc);
    chk("rst_wait_fault", 32'(fault), 32'(m_fault));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter RESET_PC SHALL be: default 32'h0000_0000, PC value loaded at reset.
REQ-003 Parameter TIMEOUT SHALL be: default 15, maximum WAIT cycles before a fetch is aborted.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 load_ir  in  1  fetch-start strobe from the controller.
REQ-007 pc_write  in  1  unconditional PC update.
REQ-008 pc_write_cond  in  1  conditional PC update.
REQ-009 alu_zero  in  1  ALU zero flag.
REQ-010 sel_mux_pc  in  1  PC source select: 0 = alu_result, 1 = alu_out.
REQ-011 alu_result  in  32  combinational ALU output (PC+4).
REQ-012 alu_out  in  32  registered ALUOut (branch target).
REQ-013 mem_req  out  1  instruction-memory read request.
REQ-014 mem_addr  out  32  read address.
REQ-015 mem_rdata  in  32  read data, valid while mem_ready=1.
REQ-016 mem_ready  in  1  read-complete handshake.
REQ-017 pc  out  32  current PC.
REQ-018 instr  out  32  instruction register contents.
REQ-019 ir_valid  out  1  one-cycle pulse when instr is updated.
REQ-020 busy  out  1  high in REQ and WAIT.
REQ-021 opcode/rd/rs1/rs2/funct3/funct7  out  7/5/5/5/3/7  instruction fields sliced from instr.
REQ-022 imm  out  32  sign-extended immediate.
REQ-023 fault  out  3  sticky flags: {timeout, misaligned, overrun}.

Function
REQ-024 The fetch FSM SHALL have the states IDLE, REQ, WAIT and DONE.
REQ-025 IDLE: if load_ir=1, the FSM SHALL latch pc into mem_addr and go to REQ; if pc[1:0]!=0, it SHALL instead load instr=0, set misaligned and go to DONE without a request.
REQ-026 REQ: mem_req SHALL be 1 for exactly one cycle, the timeout counter SHALL be cleared, and the next state SHALL be WAIT.
REQ-027 WAIT: mem_req SHALL be held at 1; on mem_ready=1 the FSM SHALL capture instr<=mem_rdata and go to DONE; otherwise the counter SHALL increment, and when counter==TIMEOUT the FSM SHALL set timeout, load instr=0 and go to DONE.
REQ-028 DONE: ir_valid SHALL be 1 for one cycle, then the FSM SHALL return to IDLE; minimum load_ir-to-ir_valid latency is 3 cycles with a zero-wait memory.
REQ-029 mem_ready seen outside WAIT SHALL be ignored.
REQ-030 load_ir seen in REQ, WAIT or DONE SHALL be dropped and SHALL set overrun.
REQ-031 PC update: if pc_write | (pc_write_cond & alu_zero), then pc <= sel_mux_pc ? alu_out : alu_result at the next edge, in any FSM state.
REQ-032 A PC update during REQ or WAIT SHALL NOT change mem_addr, so the in-flight fetch completes at the old address.
REQ-033 When load_ir and a PC update occur in the same IDLE cycle, the fetch SHALL use the pre-update PC.
REQ-034 imm SHALL be decoded from opcode as follows:
  - 0000011/0010011/1100111: I-type, instr[31:20].
  - 0100011: S-type.
  - 1100011: SB-type, bit0=0.
  - 0110111: U-type, {instr[31:12],12'b0}.
  - all other opcodes: imm=0.
  All immediates SHALL be sign-extended from instr[31].
REQ-035 Decode outputs SHALL be combinational from instr only.
REQ-036 The fault flags SHALL clear only on rst.

Reset
REQ-037 On rst=1 at a clock edge, the block SHALL reset to: pc=RESET_PC, instr=0, mem_addr=0, mem_req=0, ir_valid=0, busy=0, fault=0, counter=0, state IDLE.
REQ-038 Reset SHALL override any in-flight fetch, and a mem_ready arriving after reset SHALL be ignored.

Structure
REQ-039 Opcode constants, the fetch-state enum and the fault bit indices SHALL live in the shared package riscv_pkg.
REQ-040 Immediate decoding SHALL be a sub-module, imm_gen (combinational, instr in, imm out).

Verification
REQ-041 Zero-wait fetch: RESET_PC=0, mem[0]=32'h00500093, load_ir at cycle 1, mem_ready immediately -> ir_valid at cycle 3, instr=32'h00500093, rd=1, imm=5.
REQ-042 Branch: pc_write_cond=1, alu_zero=1, sel_mux_pc=1, alu_out=32'h40 -> pc=32'h40 next cycle; the same stimulus with alu_zero=0 -> pc unchanged.
REQ-043 Timeout: load_ir with mem_ready never asserted -> after 15 WAIT cycles, fault[2]=1, instr=0, ir_valid pulses, FSM returns to IDLE.
REQ-044 Misaligned: pc=32'h6 with load_ir -> no mem_req, fault[1]=1, instr=0, ir_valid after 1 cycle.
REQ-045 Overrun and in-flight PC write: load_ir again during WAIT plus pc_write to 32'h100 -> fault[0]=1, mem_addr unchanged, pc=32'h100.
REQ-046 Reset mid-WAIT: assert rst, then drive mem_ready -> pc=RESET_PC, no ir_valid pulse.
